// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared state type, default grid constants and spawn helpers for the frog controller
package frog_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int DEF_GRID_COLS = 20;
  localparam int DEF_GRID_ROWS = 15;
  localparam int DEF_COL_W     = 5;
  localparam int DEF_ROW_W     = 4;

  function automatic int spawn_col(input int grid_cols);
    return grid_cols / 2;
  endfunction

  function automatic int spawn_row(input int grid_rows);
    return grid_rows - 1;
  endfunction

endpackage

// File: rtl/frog_collision_check.sv
// rtl/frog_collision_check.sv - combinational frog-versus-cars equality check
module frog_collision_check #(
  parameter int NUM_CARS = 11,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 4
) (
  input  logic [COL_W-1:0]          frog_col,
  input  logic [ROW_W-1:0]          frog_row,
  input  logic [NUM_CARS*COL_W-1:0] car_x,
  input  logic [NUM_CARS*ROW_W-1:0] car_y,
  output logic                      hit
);

  // The frog is always on-grid, so an off-grid car can never compare equal.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if ((car_x[i*COL_W +: COL_W] == frog_col) && (car_y[i*ROW_W +: ROW_W] == frog_row)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frog_controller.sv
// rtl/frog_controller.sv - frog movement, collision, lives/score and game-over FSM; FROG_WRAP_EN enables horizontal wrap
module frog_controller
  import frog_pkg::*;
#(
  parameter int GRID_COLS  = DEF_GRID_COLS,
  parameter int GRID_ROWS  = DEF_GRID_ROWS,
  parameter int COL_W      = DEF_COL_W,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int NUM_CARS   = 11,
  parameter int LIVES      = 3,
  parameter int LIVES_W    = 2,
  parameter int SCORE_W    = 8,
  parameter int HIT_CYCLES = 50000000,
  parameter int BLINK_BIT  = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_left,
  input  logic                      btn_down,
  input  logic                      btn_up,
  input  logic                      btn_right,
  input  logic                      restart,
  input  logic [NUM_CARS*COL_W-1:0] car_x,
  input  logic [NUM_CARS*ROW_W-1:0] car_y,
  output logic [COL_W-1:0]          frog_col,
  output logic [ROW_W-1:0]          frog_row,
  output logic                      frog_visible,
  output logic                      collision_detected,
  output logic                      frog_at_top,
  output logic [LIVES_W-1:0]        lives,
  output logic [SCORE_W-1:0]        score,
  output logic                      game_over
);

  // Counter is wide enough for both the freeze length and the blink tap.
  localparam int HCW = ($clog2(HIT_CYCLES) > BLINK_BIT) ? $clog2(HIT_CYCLES) : BLINK_BIT + 1;
  localparam logic [HCW-1:0]     HIT_LAST   = HCW'(HIT_CYCLES - 1);
  localparam logic [COL_W-1:0]   SPAWN_COL  = COL_W'(spawn_col(GRID_COLS));
  localparam logic [ROW_W-1:0]   SPAWN_ROW  = ROW_W'(spawn_row(GRID_ROWS));
  localparam logic [COL_W-1:0]   COL_MAX    = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0]   ROW_MAX    = ROW_W'(GRID_ROWS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t           state;
  logic [HCW-1:0]   hit_cnt;
  logic [HCW-1:0]   hit_nxt;
  logic             move_block;
  logic             hit;
  logic             any_btn;
  logic             all_btn;
  logic             mv_ok;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;

  frog_collision_check #(
    .NUM_CARS (NUM_CARS),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_collision (
    .frog_col (frog_col),
    .frog_row (frog_row),
    .car_x    (car_x),
    .car_y    (car_y),
    .hit      (hit)
  );

  assign any_btn = btn_left | btn_down | btn_up | btn_right;
  assign all_btn = btn_left & btn_down & btn_up & btn_right;
  assign hit_nxt = hit_cnt + 1'b1;

  // Only the highest-priority pressed button is considered; if it is blocked, nothing moves.
  always_comb begin
    mv_ok   = 1'b0;
    nxt_col = frog_col;
    nxt_row = frog_row;
    if (btn_left) begin
      if (frog_col != '0) begin
        mv_ok   = 1'b1;
        nxt_col = frog_col - 1'b1;
      end
`ifdef FROG_WRAP_EN
      else begin
        mv_ok   = 1'b1;
        nxt_col = COL_MAX;
      end
`endif
    end else if (btn_down) begin
      if (frog_row != ROW_MAX) begin
        mv_ok   = 1'b1;
        nxt_row = frog_row + 1'b1;
      end
    end else if (btn_up) begin
      if (frog_row != '0) begin
        mv_ok   = 1'b1;
        nxt_row = frog_row - 1'b1;
      end
    end else if (btn_right) begin
      if (frog_col != COL_MAX) begin
        mv_ok   = 1'b1;
        nxt_col = frog_col + 1'b1;
      end
`ifdef FROG_WRAP_EN
      else begin
        mv_ok   = 1'b1;
        nxt_col = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= PLAY;
      frog_col           <= SPAWN_COL;
      frog_row           <= SPAWN_ROW;
      lives              <= LIVES_INIT;
      score              <= '0;
      hit_cnt            <= '0;
      move_block         <= 1'b1;
      collision_detected <= 1'b0;
      frog_at_top        <= 1'b0;
      frog_visible       <= 1'b1;
      game_over          <= 1'b0;
    end else begin
      collision_detected <= 1'b0;
      frog_at_top        <= 1'b0;
      if (!any_btn) begin
        move_block <= 1'b0;
      end
      if (restart) begin
        state        <= PLAY;
        lives        <= LIVES_INIT;
        score        <= '0;
        hit_cnt      <= '0;
        frog_col     <= SPAWN_COL;
        frog_row     <= SPAWN_ROW;
        move_block   <= 1'b1;
        frog_visible <= 1'b1;
        game_over    <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (hit) begin
              collision_detected <= 1'b1;
              lives              <= (lives != '0) ? lives - 1'b1 : '0;
              state              <= HIT;
              hit_cnt            <= '0;
              frog_visible       <= 1'b0;
            end else if (frog_row == '0) begin
              frog_at_top <= 1'b1;
              score       <= (score != '1) ? score + 1'b1 : score;
              frog_col    <= SPAWN_COL;
              frog_row    <= SPAWN_ROW;
              move_block  <= 1'b1;
            end else if (all_btn) begin
              frog_col   <= SPAWN_COL;
              frog_row   <= SPAWN_ROW;
              move_block <= 1'b1;
            end else if (!move_block && mv_ok) begin
              frog_col   <= nxt_col;
              frog_row   <= nxt_row;
              move_block <= 1'b1;
            end
          end
          HIT: begin
            if (hit_cnt == HIT_LAST) begin
              hit_cnt <= '0;
              if (lives == '0) begin
                state        <= OVER;
                game_over    <= 1'b1;
                frog_visible <= 1'b0;
              end else begin
                state        <= PLAY;
                frog_col     <= SPAWN_COL;
                frog_row     <= SPAWN_ROW;
                move_block   <= 1'b1;
                frog_visible <= 1'b1;
              end
            end else begin
              hit_cnt      <= hit_nxt;
              frog_visible <= hit_nxt[BLINK_BIT];
            end
          end
          OVER: begin
            game_over    <= 1'b1;
            frog_visible <= 1'b0;
          end
          default: begin
            state <= PLAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frog_controller.sv
// tb/tb_frog_controller.sv - table-driven and directed self-checking bench for frog_controller
module tb_frog_controller;

  localparam int COL_W    = 5;
  localparam int ROW_W    = 4;
  localparam int NUM_CARS = 11;
  localparam int HITC     = 16;
  localparam int BLINK    = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      btn_left = 1'b0;
  logic                      btn_down = 1'b0;
  logic                      btn_up = 1'b0;
  logic                      btn_right = 1'b0;
  logic                      restart = 1'b0;
  logic [NUM_CARS*COL_W-1:0] car_x = '1;
  logic [NUM_CARS*ROW_W-1:0] car_y = '1;
  logic [COL_W-1:0]          frog_col;
  logic [ROW_W-1:0]          frog_row;
  logic                      frog_visible;
  logic                      collision_detected;
  logic                      frog_at_top;
  logic [1:0]                lives;
  logic [7:0]                score;
  logic                      game_over;

  frog_controller #(
    .GRID_COLS  (20),
    .GRID_ROWS  (15),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W),
    .NUM_CARS   (NUM_CARS),
    .LIVES      (3),
    .LIVES_W    (2),
    .SCORE_W    (8),
    .HIT_CYCLES (HITC),
    .BLINK_BIT  (BLINK)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_left           (btn_left),
    .btn_down           (btn_down),
    .btn_up             (btn_up),
    .btn_right          (btn_right),
    .restart            (restart),
    .car_x              (car_x),
    .car_y              (car_y),
    .frog_col           (frog_col),
    .frog_row           (frog_row),
    .frog_visible       (frog_visible),
    .collision_detected (collision_detected),
    .frog_at_top        (frog_at_top),
    .lives              (lives),
    .score              (score),
    .game_over          (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       rs;
    int         col;
    int         row;
    int         lv;
    int         sc;
    int         top;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;
  int   wcol;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic [3:0] b, input logic r, input int c, input int rw,
                     input int l, input int s, input int t);
    vec_t v;
    v.btn = b; v.rs = r; v.col = c; v.row = rw; v.lv = l; v.sc = s; v.top = t;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_left, btn_down, btn_up, btn_right} = b;
  endtask

  task automatic set_car(input int i, input int x, input int y);
    car_x[i*COL_W +: COL_W] = COL_W'(x);
    car_y[i*ROW_W +: ROW_W] = ROW_W'(y);
  endtask

  // Frog at spawn, car0 at (10,13): hop up into it and ride out the freeze.
  task automatic do_hit(input int exp_lives);
    set_btn(4'b0000); tick();
    set_btn(4'b0010); tick();
    chk("hit_move_row", frog_row, 13);
    chk("hit_no_early_coll", collision_detected, 0);
    set_btn(4'b0000); tick();
    chk("hit_coll", collision_detected, 1);
    chk("hit_lives", lives, exp_lives);
    chk("hit_vis0", frog_visible, 0);
    for (int k = 1; k < HITC; k++) begin
      set_btn(4'b1000);
      tick();
      chk($sformatf("blink%0d", k), frog_visible, (k >> BLINK) & 1);
      chk($sformatf("frozen_row%0d", k), frog_row, 13);
      chk($sformatf("coll_pulse%0d", k), collision_detected, 0);
    end
    set_btn(4'b0000);
    tick();
    if (exp_lives > 0) begin
      chk("respawn_col", frog_col, 10);
      chk("respawn_row", frog_row, 14);
      chk("respawn_vis", frog_visible, 1);
      chk("respawn_go", game_over, 0);
    end else begin
      chk("over_go", game_over, 1);
      chk("over_vis", frog_visible, 0);
      chk("over_lives", lives, 0);
    end
  endtask

  initial begin
`ifdef FROG_WRAP_EN
    wcol = 19;
`else
    wcol = 0;
`endif
    // Movement/score table: {buttons L D U R, restart, col, row, lives, score, at_top}.
    add(4'b0000, 0, 10, 14, 3, 0, 0);
    for (int r = 13; r >= 0; r--) begin
      add(4'b0010, 0, 10, r, 3, 0, 0);
      if (r == 0) add(4'b0000, 0, 10, 14, 3, 1, 1);
      else        add(4'b0000, 0, 10, r, 3, 0, 0);
    end
    add(4'b0000, 0, 10, 14, 3, 1, 0);
    for (int i = 0; i < 100; i++) add(4'b1000, 0, 9, 14, 3, 1, 0);
    add(4'b0000, 0, 9, 14, 3, 1, 0);
    for (int c = 8; c >= 0; c--) begin
      add(4'b1000, 0, c, 14, 3, 1, 0);
      add(4'b0000, 0, c, 14, 3, 1, 0);
    end
    add(4'b1000, 0, wcol, 14, 3, 1, 0);
    add(4'b0000, 0, wcol, 14, 3, 1, 0);
    add(4'b0100, 0, wcol, 14, 3, 1, 0);
    add(4'b0000, 0, wcol, 14, 3, 1, 0);
    add(4'b0000, 1, 10, 14, 3, 0, 0);
    add(4'b0000, 0, 10, 14, 3, 0, 0);
    add(4'b1001, 0, 9, 14, 3, 0, 0);
    add(4'b0000, 0, 9, 14, 3, 0, 0);
    for (int c = 8; c >= 4; c--) begin
      add(4'b1000, 0, c, 14, 3, 0, 0);
      add(4'b0000, 0, c, 14, 3, 0, 0);
    end
    for (int r = 13; r >= 7; r--) begin
      add(4'b0010, 0, 4, r, 3, 0, 0);
      add(4'b0000, 0, 4, r, 3, 0, 0);
    end
    add(4'b1111, 0, 10, 14, 3, 0, 0);
    add(4'b0000, 0, 10, 14, 3, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_col", frog_col, 10);
    chk("rst_row", frog_row, 14);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_vis", frog_visible, 1);
    chk("rst_go", game_over, 0);
    chk("rst_coll", collision_detected, 0);
    chk("rst_top", frog_at_top, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_btn(vecs[i].btn);
      restart = vecs[i].rs;
      tick();
      chk($sformatf("v%0d_col", i), frog_col, vecs[i].col);
      chk($sformatf("v%0d_row", i), frog_row, vecs[i].row);
      chk($sformatf("v%0d_lives", i), lives, vecs[i].lv);
      chk($sformatf("v%0d_score", i), score, vecs[i].sc);
      chk($sformatf("v%0d_top", i), frog_at_top, vecs[i].top);
      chk($sformatf("v%0d_coll", i), collision_detected, 0);
    end
    restart = 1'b0;

    // Three hits lead to game over; buttons are then ignored until restart.
    set_car(0, 10, 13);
    do_hit(2);
    do_hit(1);
    do_hit(0);
    set_btn(4'b1000); tick();
    chk("over_ignore_col", frog_col, 10);
    chk("over_ignore_row", frog_row, 13);
    chk("over_hold_go", game_over, 1);
    set_btn(4'b0000);
    restart = 1'b1; tick();
    restart = 1'b0;
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_go", game_over, 0);
    chk("restart_vis", frog_visible, 1);
    chk("restart_row", frog_row, 14);

    // Async reset in the middle of a freeze.
    set_btn(4'b0000); tick();
    set_btn(4'b0010); tick();
    set_btn(4'b0000); tick();
    chk("mid_coll", collision_detected, 1);
    repeat (5) tick();
    chk("mid_vis_blink", frog_visible, 1);
    rst = 1'b1;
    #1;
    chk("arst_lives", lives, 3);
    chk("arst_vis", frog_visible, 1);
    chk("arst_row", frog_row, 14);
    chk("arst_go", game_over, 0);
    tick();
    rst = 1'b0;
    do_hit(2);

    // Car on row 0: collision beats reaching the top.
    set_car(0, 10, 0);
    set_btn(4'b0000); tick();
    for (int i = 0; i < 14; i++) begin
      set_btn(4'b0010); tick();
      set_btn(4'b0000);
      if (i < 13) tick();
    end
    chk("top_row0", frog_row, 0);
    tick();
    chk("both_coll", collision_detected, 1);
    chk("both_top", frog_at_top, 0);
    chk("both_score", score, 0);
    chk("both_lives", lives, 1);
    repeat (HITC) tick();
    chk("both_resp_row", frog_row, 14);
    chk("both_resp_score", score, 0);
    chk("both_resp_go", game_over, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frog_controller.md
Name: frog_controller

Overview:
Parametrised next-generation frog movement and life manager for the Frogger game. Takes debounced buttons and a packed vector of N car positions. Owns frog position, collision detection, lives, score, hit/respawn timing and game-over. Feeds the renderer (position, visibility) and the HUD (lives, score, state).

Parameters:
GRID_COLS, 20, grid width in cells
GRID_ROWS, 15, grid height in cells
COL_W, 5, column coordinate width (must satisfy 2^COL_W >= GRID_COLS)
ROW_W, 4, row coordinate width (must satisfy 2^ROW_W >= GRID_ROWS)
NUM_CARS, 11, number of car positions checked
LIVES, 3, lives at game start (1..2^LIVES_W-1)
LIVES_W, 2, lives counter width
SCORE_W, 8, score counter width
HIT_CYCLES, 50000000, length of the HIT freeze in clk cycles (>=2)
BLINK_BIT, 22, hit-counter bit that drives frog_visible during HIT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_left  in  1  debounced, level
btn_down  in  1  debounced, level
btn_up  in  1  debounced, level
btn_right  in  1  debounced, level
restart  in  1  start a new game (level, sampled on clk)
car_x  in  NUM_CARS*COL_W  packed car columns; car i is at [i*COL_W +: COL_W]
car_y  in  NUM_CARS*ROW_W  packed car rows; car i is at [i*ROW_W +: ROW_W]
frog_col  out  COL_W  frog column (registered)
frog_row  out  ROW_W  frog row (registered)
frog_visible  out  1  renderer enable
collision_detected  out  1  one-cycle pulse when a hit is taken
frog_at_top  out  1  one-cycle pulse when the frog reaches row 0
lives  out  LIVES_W  remaining lives
score  out  SCORE_W  number of successful crossings
game_over  out  1  high while in the OVER state

Behaviour:
- Reset (async, rst=1):
  - state=PLAY; frog_col=GRID_COLS/2 (10); frog_row=GRID_ROWS-1 (14).
  - lives=LIVES; score=0; hit_cnt=0; move_block=1.
  - collision_detected=0; frog_at_top=0; frog_visible=1; game_over=0.
- Spawn: column GRID_COLS/2, row GRID_ROWS-1. Every respawn sets move_block=1.
- move_block:
  - Cleared in any cycle where all four buttons are low.
  - A move is allowed only when move_block=0, then move_block is set. This gives one hop per press.
- PLAY state:
  - Move priority is left > down > up > right. Clamp at grid edges: a blocked direction does nothing and does not set move_block.
  - Position updates one cycle after the button is sampled.
  - All four buttons high: respawn, no life lost.
  - Collision is evaluated combinationally from the registered position vs all NUM_CARS cars, and registered. A frog that moves into a car at edge n produces collision_detected=1 at edge n+1.
  - On collision: lives decrements, saturating at 0; collision_detected pulses for 1 cycle; state goes to HIT with hit_cnt=0. The position is frozen on the hit cell, and any move in that cycle is discarded.
  - On frog_row==0 with no collision: frog_at_top pulses; score increments, saturating at 2^SCORE_W-1; respawn next cycle.
  - Collision and top in the same cycle: collision wins, no score.
- HIT state:
  - Buttons ignored; frog_visible = hit_cnt[BLINK_BIT]; hit_cnt increments.
  - At hit_cnt==HIT_CYCLES-1: if lives==0, go to OVER; else respawn and go to PLAY.
- OVER state:
  - game_over=1; frog_visible=0; buttons ignored; lives and score held.
- restart=1 (any state):
  - Next cycle: PLAY, full lives, score=0, respawn.
  - Overrides every other event in that cycle.
- Car inputs are assumed stable per clk. A car at an off-grid coordinate never matches.

Optional Feature:
FROG_WRAP_EN
- Defined: horizontal moves wrap. Left from column 0 goes to GRID_COLS-1; right from GRID_COLS-1 goes to 0. Both set move_block. Vertical moves still clamp.
- Undefined: horizontal moves clamp at the edges, as specified above.

Decomposition:
- Package frog_pkg:
  - state typedef {PLAY, HIT, OVER} (2 bits).
  - Default grid constants and the spawn-coordinate functions.
- One sub-module, frog_collision_check (parameters NUM_CARS, COL_W, ROW_W): purely combinational OR-reduction of per-car equality compares, output hit.
- The FSM, counters and movement stay in frog_controller.

Test Plan:
- Reset, then btn_up pulsed 14 times with release in between → frog_row steps 14→0; frog_at_top pulses once; score=1; frog returns to (10,14).
- btn_left held for 100 cycles → frog_col 10→9 only; release and press again → 8. From column 0, btn_left → stays 0 without FROG_WRAP_EN, goes to 19 with it.
- car0=(10,13), frog at (10,14), btn_up → collision_detected high 2 cycles after the press sample; lives 3→2; frog_visible blinks; after HIT_CYCLES (set to 16 in the bench) the frog is at (10,14).
- Three hits → after the third HIT, game_over=1, lives=0; buttons ignored; restart → lives=3, score=0, PLAY.
- All four buttons high at (4,7) → respawn to (10,14), lives unchanged. btn_left+btn_right together → left wins.
- Assert rst during HIT mid-count → immediately PLAY, lives=3, hit_cnt=0, frog_visible=1. Collision and row 0 in the same cycle (car at (10,0)) → collision wins, score unchanged.
